// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters, active-video/sync decode, line and frame
// strobes, frame counter, plus a fixed-length delay line that aligns de/hs/vs to the pixel pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       de,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       de_d,
    output logic       hs_d,
    output logic       vs_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE must be in 0..4");
    end

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       vid_q, vid_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_q, line_d;
    logic       frame_q, frame_d;
    logic [7:0] fcnt_q, fcnt_d;

    // Decode from the next position so the registered flags line up with hpos/vpos.
    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (en) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end
        vid_d   = ({1'b0, hpos_d} < H_ACT) && ({1'b0, vpos_d} < V_ACT);
        hsync_d = (({1'b0, hpos_d} >= HS_START) && ({1'b0, hpos_d} < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d = (({1'b0, vpos_d} >= VS_START) && ({1'b0, vpos_d} < VS_END)) ? VS_POL : ~VS_POL;
        line_d  = en && (hpos_d == 10'd0);
        frame_d = line_d && (vpos_d == 10'd0);
        fcnt_d  = fcnt_q + {7'd0, frame_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos_q  <= H_LAST;
            vpos_q  <= V_LAST;
            vid_q   <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            vid_q   <= vid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign de          = vid_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_cnt   = fcnt_q;

    // The delay line runs on every clk, regardless of en, to track the downstream pipeline.
    if (PIPE == 0) begin : g_nopipe
        assign de_d = vid_q;
        assign hs_d = hsync_q;
        assign vs_d = vsync_q;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PIPE; i++) begin
                    pipe_q[i] <= {1'b0, ~HS_POL, ~VS_POL};
                end
            end else begin
                pipe_q[0] <= {vid_q, hsync_q, vsync_q};
                for (int i = 1; i < PIPE; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign de_d = pipe_q[PIPE-1][2];
        assign hs_d = pipe_q[PIPE-1][1];
        assign vs_d = pipe_q[PIPE-1][0];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing with PIPE=2 and PIPE=0, plus a tiny raster
// (HS_POL=1, VS_POL=1) run past a frame-counter wrap, all against a position-index model.
module tb_vga_timing_gen;
    localparam int W = 33;

    // Small raster: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6).
    localparam int S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_FRAME = 48;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic [9:0] a_hpos, a_vpos, z_hpos, z_vpos, s_hpos, s_vpos;
    logic       a_de, a_hs, a_vs, a_ls, a_fs, a_de_d, a_hs_d, a_vs_d;
    logic       z_de, z_hs, z_vs, z_ls, z_fs, z_de_d, z_hs_d, z_vs_d;
    logic       s_de, s_hs, s_vs, s_ls, s_fs, s_de_d, s_hs_d, s_vs_d;
    logic [7:0] a_fc, z_fc, s_fc;

    vga_timing_gen #(.PIPE(2)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .hpos(a_hpos), .vpos(a_vpos), .de(a_de), .hs(a_hs), .vs(a_vs),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc),
        .de_d(a_de_d), .hs_d(a_hs_d), .vs_d(a_vs_d)
    );

    vga_timing_gen #(.PIPE(0)) dut_z (
        .clk(clk), .rst(rst), .en(en),
        .hpos(z_hpos), .vpos(z_vpos), .de(z_de), .hs(z_hs), .vs(z_vs),
        .line_start(z_ls), .frame_start(z_fs), .frame_cnt(z_fc),
        .de_d(z_de_d), .hs_d(z_hs_d), .vs_d(z_vs_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(2)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en),
        .hpos(s_hpos), .vpos(s_vpos), .de(s_de), .hs(s_hs), .vs(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc),
        .de_d(s_de_d), .hs_d(s_hs_d), .vs_d(s_vs_d)
    );

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_z_q[$];
    logic [W-1:0] exp_s_q[$];
    logic [2:0]   hist_m[$];
    logic [2:0]   hist_s[$];

    int p;        // enabled clock edges since reset release
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Expected word {hpos,vpos,de,hs,vs,line_start,frame_start,frame_cnt} after p enabled edges.
    function automatic logic [W-1:0] model(input int pp, input bit stb,
                                           input int ha, input int hf, input int hsw, input int hb,
                                           input int va, input int vf, input int vsw, input int vb,
                                           input bit hpol, input bit vpol);
        int ht, vt, h, v, fc;
        bit d, hsv, vsv, ls, fs;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (pp == 0) begin
            h = ht - 1; v = vt - 1; fc = 0;
        end else begin
            h  = (pp - 1) % ht;
            v  = ((pp - 1) / ht) % vt;
            fc = ((pp - 1) / (ht * vt) + 1) % 256;
        end
        d   = (h < ha) && (v < va);
        hsv = (h >= ha + hf && h < ha + hf + hsw) ? hpol : !hpol;
        vsv = (v >= va + vf && v < va + vf + vsw) ? vpol : !vpol;
        ls  = stb && (h == 0);
        fs  = ls && (v == 0);
        return {10'(h), 10'(v), d, hsv, vsv, ls, fs, 8'(fc)};
    endfunction

    function automatic logic [W-1:0] model_m(input int pp, input bit stb);
        return model(pp, stb, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic logic [W-1:0] model_s(input int pp, input bit stb);
        return model(pp, stb, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hist_init();
        hist_m.delete();
        hist_s.delete();
        repeat (3) begin
            hist_m.push_back(model_m(0, 1'b0)[12:10]);
            hist_s.push_back(model_s(0, 1'b0)[12:10]);
        end
    endtask

    task automatic check_reset(input string tag);
        logic [W-1:0] rm, rs;
        rm = model_m(0, 1'b0);
        rs = model_s(0, 1'b0);
        check_eq({tag, "_a"}, {a_hpos, a_vpos, a_de, a_hs, a_vs, a_ls, a_fs, a_fc}, rm);
        check_eq({tag, "_z"}, {z_hpos, z_vpos, z_de, z_hs, z_vs, z_ls, z_fs, z_fc}, rm);
        check_eq({tag, "_s"}, {s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs, s_fc}, rs);
        check_eq({tag, "_a_dly"}, {a_de_d, a_hs_d, a_vs_d}, rm[12:10]);
        check_eq({tag, "_s_dly"}, {s_de_d, s_hs_d, s_vs_d}, rs[12:10]);
    endtask

    // Drive one cycle, queue expectations, then compare just after the edge.
    task automatic step(input bit en_v);
        logic [W-1:0] em, es;
        en = en_v;
        if (en_v) p++;
        em = model_m(p, en_v);
        es = model_s(p, en_v);
        exp_a_q.push_back(em);
        exp_z_q.push_back(em);
        exp_s_q.push_back(es);
        hist_m.push_back(em[12:10]);
        hist_s.push_back(es[12:10]);
        if (hist_m.size() > 3) void'(hist_m.pop_front());
        if (hist_s.size() > 3) void'(hist_s.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        check_eq($sformatf("a_out@%0d", cyc), {a_hpos, a_vpos, a_de, a_hs, a_vs, a_ls, a_fs, a_fc},
                 exp_a_q.pop_front());
        check_eq($sformatf("z_out@%0d", cyc), {z_hpos, z_vpos, z_de, z_hs, z_vs, z_ls, z_fs, z_fc},
                 exp_z_q.pop_front());
        check_eq($sformatf("s_out@%0d", cyc), {s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs, s_fc},
                 exp_s_q.pop_front());
        check_eq($sformatf("a_dly@%0d", cyc), {a_de_d, a_hs_d, a_vs_d}, hist_m[0]);
        check_eq($sformatf("z_dly@%0d", cyc), {z_de_d, z_hs_d, z_vs_d}, hist_m[2]);
        check_eq($sformatf("s_dly@%0d", cyc), {s_de_d, s_hs_d, s_vs_d}, hist_s[0]);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        p   = 0;
        hist_init();
        #1;
        check_reset("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two full lines free-running, covering de, hs window and line wrap.
        repeat (1700) step(1'b1);

        // Alternating enable.
        for (int i = 0; i < 200; i++) step(i % 2 == 0);

        // Park at the end of a line with en low, then resume.
        while (((p - 1) % 800) != 799) step(1'b1);
        repeat (5) step(1'b0);
        repeat (3) step(1'b1);

        repeat (500) step(1'($urandom_range(0, 1)));

        // Asynchronous reset mid-frame, checked before any clock edge.
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        p = 0;
        hist_init();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Enough frames of the small raster to wrap frame_cnt past 255.
        while (p < 260 * S_FRAME + 10) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates raster timing for the VGA output stage: horizontal and vertical position counters, active-video enable, sync pulses, and line and frame strobes.
- Sits directly upstream of the `vga` pixel/RGB output block. That block consumes `hpos`/`vpos`/`de` to compute colour, and drives `hs`/`vs` from the pipeline-aligned `hs_d`/`vs_d`.
- Defaults give 640x480 at 60 Hz from a 25.175 MHz pixel rate.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `HS_POL`, 0: active level of `hs`/`hs_d` (0 = active-low)
- `VS_POL`, 0: active level of `vs`/`vs_d`
- `PIPE`, 2: delay of `de_d`/`hs_d`/`vs_d` in clk cycles, legal 0..4

Ports:
- `clk`, in, 1: clock
- `rst`, in, 1: reset, asynchronous, active-high
- `en`, in, 1: pixel enable; counters advance only in cycles with en=1
- `hpos`, out, 10: horizontal counter, 0..H_TOTAL-1
- `vpos`, out, 10: vertical counter, 0..V_TOTAL-1
- `de`, out, 1: active video, high when hpos<H_ACTIVE and vpos<V_ACTIVE
- `hs`, out, 1: horizontal sync
- `vs`, out, 1: vertical sync
- `line_start`, out, 1: one-cycle pulse when hpos becomes 0
- `frame_start`, out, 1: one-cycle pulse when (hpos,vpos) becomes (0,0)
- `frame_cnt`, out, 8: frames started since reset, wraps
- `de_d`, `hs_d`, `vs_d`, out, 1 each: `de`/`hs`/`vs` delayed by PIPE clk cycles

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Both must be ≤1024; this is an elaboration-time check.

Counter behaviour:
- On a cycle with en=1: hpos increments. At H_TOTAL-1 it wraps to 0 and vpos increments.
- vpos wraps from V_TOTAL-1 to 0 on the same cycle hpos wraps.
- On a cycle with en=0: all counters and decoded outputs hold.
- Strobes (`line_start`, `frame_start`) go low on a cycle with en=0.

Decoded outputs:
- All outputs are registered. `de`, `hs`, `vs` are decoded from the next counter value, so they are exactly coincident with the `hpos`/`vpos` values shown in the same cycle.
- `hs` is at HS_POL level iff H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC (656..751). Otherwise it is at ~HS_POL.
- `vs` is at VS_POL level iff V_ACTIVE+V_FP ≤ vpos < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line. Otherwise it is at ~VS_POL.

Strobes and frame count:
- `line_start` is high for exactly the one clk in which hpos transitions to 0.
- `frame_start` is high for the one clk in which (hpos,vpos) transitions to (0,0). `line_start` is also high in that cycle.
- `frame_cnt` increments, modulo 256, in the same cycle `frame_start` is high.

Delay line:
- A PIPE-stage shift register on {de,hs,vs}.
- It shifts every clk, independent of `en`.
- PIPE=0 makes `de_d`/`hs_d`/`vs_d` equal to `de`/`hs`/`vs`.

## Timing
Reset (asynchronous, takes effect immediately; legal mid-frame):
- hpos=H_TOTAL-1, vpos=V_TOTAL-1
- de=0, hs=~HS_POL, vs=~VS_POL
- line_start=0, frame_start=0, frame_cnt=0
- All delay stages: de=0, hs=~HS_POL, vs=~VS_POL

After reset:
- The first clk with en=1 moves to hpos=0, vpos=0, de=1, line_start=1, frame_start=1, frame_cnt=1.
- Reset mid-operation discards the current position. Timing restarts at the first frame as above, and no partial sync pulse is emitted after release.

Latency:
- `hpos`/`vpos`/`de`/`hs`/`vs`: 1 clk from the enabling edge.
- `*_d` outputs: PIPE further clks.

Boundary cases:
- Line wrap (799→0): vpos+1 in the same cycle; line_start=1.
- Frame wrap (799,524)→(0,0): frame_start=1, frame_cnt+1.
- en held low across a wrap point: the wrap and its strobes occur on the first subsequent en=1 cycle, exactly once.
- frame_cnt 255→0: no flag raised.

## Test plan
- Assert rst mid-run; check all reset values immediately, before any clk edge. Release rst with en=1: first edge gives hpos=0, vpos=0, de=1, frame_start=1, frame_cnt=1.
- Free-run a full line with en=1 and defaults:
  - de=1 for hpos 0..639, de=0 for 640..799
  - hs=0 exactly for hpos 656..751 (96 clks)
  - line_start pulses once per 800 clks
- Free-run a full frame:
  - vs=0 for vpos 490..491 (1600 clks)
  - de=0 for vpos ≥480
  - frame_start once per 420000 clks; frame_cnt increments by 1
- Toggle en 1010…: counters advance only on en=1 cycles and hold otherwise. Hold en=0 at hpos=799 for 5 clks: line_start pulses once, on the next en=1 cycle.
- PIPE=2: `de_d`/`hs_d` equal `de`/`hs` delayed exactly 2 clks across an hs edge. With PIPE=0 they are identical.
- Small parameters (H 4/1/2/1, V 3/1/1/1): run 260 frames. frame_cnt wraps 255→0, and hs/vs windows match the formulas; HS_POL=1 inverts hs.
